// File: rtl/result_uart_tx_if.sv
// result_uart_tx_if
// Handshake bundle between the top level and the result UART transmitter.
//   start : transmit request, one cycle, honoured only while the transmitter is idle
//   data  : 32-bit word to send, captured on the accepting edge
//   busy  : high while a message is on the line
//   done  : one-cycle pulse when the final stop bit of a message completes
// The master modport belongs to whoever requests transmissions; the slave
// modport belongs to the transmitter itself.
interface result_uart_tx_if;
    logic        start;
    logic [31:0] data;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output data,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  data,
        output busy,
        output done
    );
endinterface

// File: rtl/result_uart_tx.sv
// result_uart_tx
// Sends a 32-bit result word over a UART 8N1 line as ten ASCII characters:
// eight uppercase hex digits (most-significant nibble first), then CR and LF.
// Lets the single-step core's Result register be read on a serial terminal.
//   CLKS_PER_BIT : clock cycles per UART bit (>= 2)
//   clk          : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   bus          : start/data request in, busy/done status out (slave side)
//   tx           : registered serial line, idle high
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              reset_n,
    result_uart_tx_if.slave   bus,
    output logic              tx
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [3:0]    char_idx;
    logic [31:0]   shadow;
    logic          busy_r;
    logic          done_r;

    logic          baud_done;
    logic [3:0]    nibble;
    logic [7:0]    cur_char;

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign baud_done = (baud_cnt == BAUD_LAST);

    // Pick the nibble for the current character, most-significant first.
    always_comb begin
        nibble = 4'h0;
        case (char_idx)
            4'd0:    nibble = shadow[31:28];
            4'd1:    nibble = shadow[27:24];
            4'd2:    nibble = shadow[23:20];
            4'd3:    nibble = shadow[19:16];
            4'd4:    nibble = shadow[15:12];
            4'd5:    nibble = shadow[11:8];
            4'd6:    nibble = shadow[7:4];
            4'd7:    nibble = shadow[3:0];
            default: nibble = 4'h0;
        endcase
    end

    // ASCII for the current character: '0'-'9', 'A'-'F', then CR and LF.
    // 0x37 + n lands on 'A' for n = 10.
    always_comb begin
        cur_char = 8'h00;
        if (char_idx == 4'd8) begin
            cur_char = 8'h0D;
        end else if (char_idx == 4'd9) begin
            cur_char = 8'h0A;
        end else if (nibble < 4'd10) begin
            cur_char = 8'h30 + {4'h0, nibble};
        end else begin
            cur_char = 8'h37 + {4'h0, nibble};
        end
    end

    // Frame state machine. tx is loaded with the level of the *next* bit on
    // the edge that ends the current one, so the line stays registered and
    // each bit lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            char_idx <= 4'd0;
            shadow   <= 32'h0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            tx       <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (bus.start) begin
                        shadow   <= bus.data;
                        char_idx <= 4'd0;
                        baud_cnt <= '0;
                        busy_r   <= 1'b1;
                        tx       <= 1'b0;
                        state    <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        tx       <= cur_char[0];
                        state    <= DATA_BITS;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA_BITS: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_char[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP_BIT: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (char_idx == 4'd9) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            tx     <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            // Next character starts with no idle gap.
                            char_idx <= char_idx + 4'd1;
                            tx       <= 1'b0;
                            state    <= START_BIT;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx
// Self-checking bench for result_uart_tx with CLKS_PER_BIT = 4.
// Expected line levels come from a timing model: cycle k of a message belongs
// to character k/40, bit slot (k%40)/4, where slot 0 is the start bit, slots
// 1..8 are data bits LSB first and slot 9 is the stop bit. Characters are
// computed from the word with plain arithmetic. A mid-bit sampler also
// decodes each received byte and compares it with the expected ASCII.
module tb_result_uart_tx;

    localparam int C   = 4;
    localparam int MSG = 100 * C;

    logic clk;
    logic reset_n;
    logic tx;

    int total = 0;
    int bad   = 0;

    result_uart_tx_if bus ();

    result_uart_tx #(
        .CLKS_PER_BIT (C)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .tx      (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected ASCII for character ci of a message carrying word w.
    function automatic logic [7:0] exp_char(input logic [31:0] w, input int ci);
        int n;
        if (ci == 8) return 8'h0D;
        if (ci == 9) return 8'h0A;
        n = int'((w >> (4 * (7 - ci))) & 32'hF);
        if (n < 10) return 8'(48 + n);
        return 8'(65 + n - 10);
    endfunction

    // Expected line level at cycle k after the accepting edge.
    function automatic logic exp_tx(input logic [31:0] w, input int k);
        int         ci;
        int         slot;
        logic [7:0] ch;
        ci   = k / (10 * C);
        slot = (k % (10 * C)) / C;
        ch   = exp_char(w, ci);
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return ch[slot - 1];
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line must be idle: tx=1, busy=0, done=0.
    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check_output(tag, {29'd0, tx, bus.busy, bus.done}, 32'd4);
            step();
        end
    endtask

    // Caller has set start=1 and data=word before the accepting edge.
    // Optionally injects a new data/start pulse mid-message, and optionally
    // raises start with next_word just before the done edge.
    task automatic apply_stimulus(input logic [31:0] word, input int inject_at,
                                  input logic [31:0] inject_data, input bit hold_end,
                                  input logic [31:0] next_word, input string name);
        logic [7:0] rx;
        int         slot;
        rx = 8'h00;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < MSG; k++) begin
            check_output({name, "_line"}, {29'd0, tx, bus.busy, bus.done},
                         {29'd0, exp_tx(word, k), 1'b1, 1'b0});
            if (k % C == C / 2) begin
                slot = (k % (10 * C)) / C;
                if (slot >= 1 && slot <= 8) rx[slot - 1] = tx;
            end
            if (k % (10 * C) == 10 * C - 1) begin
                check_output($sformatf("%s_char%0d", name, k / (10 * C)),
                             {24'd0, rx}, {24'd0, exp_char(word, k / (10 * C))});
            end
            if (k == inject_at) begin
                bus.data  = inject_data;
                bus.start = 1'b1;
            end else if (k == inject_at + 1) begin
                bus.start = 1'b0;
            end
            if (hold_end && k == MSG - 1) begin
                bus.data  = next_word;
                bus.start = 1'b1;
            end
            step();
        end
        check_output({name, "_done"}, {29'd0, tx, bus.busy, bus.done}, 32'd5);
    endtask

    initial begin
        logic [31:0] w;
        int          inj;

        reset_n   = 1'b1;
        bus.start = 1'b0;
        bus.data  = 32'h0;
        #2;
        reset_n = 1'b0;
        #1;
        check_output("reset_state", {29'd0, tx, bus.busy, bus.done}, 32'd4);
        repeat (3) step();
        check_output("reset_hold", {29'd0, tx, bus.busy, bus.done}, 32'd4);
        reset_n = 1'b1;
        idle_check(50, "idle_after_reset");

        // Normal word: "00000019\r\n".
        bus.data  = 32'h0000_0019;
        bus.start = 1'b1;
        apply_stimulus(32'h0000_0019, -10, 32'h0, 1'b0, 32'h0, "normal");
        step();
        idle_check(5, "normal_idle");

        // Hex letters: "DEADBEEF\r\n".
        bus.data  = 32'hDEAD_BEEF;
        bus.start = 1'b1;
        apply_stimulus(32'hDEAD_BEEF, -10, 32'h0, 1'b0, 32'h0, "hexletters");
        step();
        idle_check(5, "hex_idle");

        // Start and new data at cycle 100 must be ignored and not queued.
        bus.data  = 32'h0000_0064;
        bus.start = 1'b1;
        apply_stimulus(32'h0000_0064, 100, 32'hFFFF_FFFF, 1'b0, 32'h0, "ignore");
        step();
        idle_check(10, "ignore_idle");

        // Back-to-back: start held across the done cycle.
        bus.data  = 32'h0000_000A;
        bus.start = 1'b1;
        apply_stimulus(32'h0000_000A, -10, 32'h0, 1'b1, 32'h0000_000A, "b2b_first");
        apply_stimulus(32'h0000_000A, -10, 32'h0, 1'b0, 32'h0, "b2b_second");
        step();
        idle_check(5, "b2b_idle");

        // Random words with a random ignored start mid-message.
        for (int r = 0; r < 4; r++) begin
            w         = $urandom;
            inj       = int'($urandom_range(5, MSG - 10));
            bus.data  = w;
            bus.start = 1'b1;
            apply_stimulus(w, inj, $urandom, 1'b0, 32'h0, $sformatf("rand%0d", r));
            step();
            idle_check(3, "rand_idle");
        end

        // Reset at cycle 150 aborts immediately with no done pulse.
        w         = $urandom;
        bus.data  = w;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 150; k++) begin
            check_output("abort_line", {29'd0, tx, bus.busy, bus.done},
                         {29'd0, exp_tx(w, k), 1'b1, 1'b0});
            step();
        end
        reset_n = 1'b0;
        #1;
        check_output("abort_immediate", {29'd0, tx, bus.busy, bus.done}, 32'd4);
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("abort_hold", {29'd0, tx, bus.busy, bus.done}, 32'd4);
        end
        reset_n = 1'b1;
        idle_check(10, "abort_idle");

        // Fresh message after the abort.
        w         = $urandom;
        bus.data  = w;
        bus.start = 1'b1;
        apply_stimulus(w, -10, 32'h0, 1'b0, 32'h0, "fresh");
        step();
        idle_check(5, "fresh_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
